// File: rtl/proc_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, opcode and error codes.
package proc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_EXEC    = 3'd4,
        ST_HALTED  = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVT  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_WDOG    = 2'b10;
    localparam logic [1:0] ERR_SPUR    = 2'b11;

    // True for opcodes 100..110, which the core cannot complete; 111 is HALT.
    function automatic logic is_illegal_op(input logic [2:0] op);
        return op[2] && (op != OP_HALT);
    endfunction

    function automatic logic is_busy_state(input state_t st);
        return !((st == ST_IDLE) || (st == ST_HALTED) || (st == ST_ERROR));
    endfunction

endpackage

// File: rtl/proc_seq_wdog.sv
// Execution watchdog: loadable saturating up-counter whose terminal flag marks
// the last cycle before LIMIT is reached.
module proc_seq_wdog #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
    localparam logic [CW-1:0] TOP  = CW'(LIMIT);

    logic [CW-1:0] cnt_r;

    // Count enabled cycles, restarting on load and saturating at LIMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            cnt_r <= {CW{1'b0}};
        end else if (en && (cnt_r != TOP)) begin
            cnt_r <= cnt_r + CW'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = (cnt_r == LAST);

endmodule

// File: rtl/proc_seq_ctrl.sv
// Instruction sequencer: fetches words from program memory, issues them to the
// multicycle core with a one-cycle Run pulse and supervises completion.
module proc_seq_ctrl
    import proc_pkg::*;
#(
    parameter int AW      = 8,
    parameter int TIMEOUT = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stop,
    output logic [AW-1:0] MemAddr,
    output logic          MemRd,
    input  logic [15:0]   MemData,
    output logic [15:0]   DIN,
    output logic          Run,
    input  logic          Done,
    output logic [AW-1:0] PC,
    output logic [15:0]   InstrCount,
    output logic          Busy,
    output logic          Halted,
    output logic          Error,
    output logic [1:0]    ErrCode
);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [AW-1:0] pc_r;
    logic [15:0]   icount_r;
    logic [15:0]   din_r;
    logic [1:0]    errcode_r;
    logic          stop_pending_r;
    logic          run_r;
    logic          memrd_r;
    logic          busy_r;
    logic          halted_r;
    logic          error_r;

    logic          pc_inc_s;
    logic          clr_s;
    logic          icount_inc_s;
    logic          err_set_s;
    logic [1:0]    err_val_s;
    logic          wd_load_s;
    logic          wd_en_s;
    logic          wd_expire_s;
    logic [2:0]    op_s;

    assign op_s = MemData[15:13];

    proc_seq_wdog #(
        .LIMIT (TIMEOUT)
    ) u_wdog (
        .clk    (Clock),
        .rst    (Reset),
        .load   (wd_load_s),
        .en     (wd_en_s),
        .expire (wd_expire_s)
    );

    // Next-state and per-state control strobes.
    always_comb begin
        state_nxt_s  = state_r;
        pc_inc_s     = 1'b0;
        clr_s        = 1'b0;
        icount_inc_s = 1'b0;
        err_set_s    = 1'b0;
        err_val_s    = ERR_NONE;
        wd_load_s    = 1'b0;
        wd_en_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (Done) begin
                    state_nxt_s = ST_ERROR;
                    err_set_s   = 1'b1;
                    err_val_s   = ERR_SPUR;
                end else begin
                    state_nxt_s = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (Done) begin
                    state_nxt_s = ST_ERROR;
                    err_set_s   = 1'b1;
                    err_val_s   = ERR_SPUR;
                end else if (op_s == OP_HALT) begin
                    state_nxt_s = ST_HALTED;
                end else if (is_illegal_op(op_s)) begin
                    state_nxt_s = ST_ERROR;
                    err_set_s   = 1'b1;
                    err_val_s   = ERR_ILLEGAL;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                pc_inc_s  = 1'b1;
                wd_load_s = 1'b1;
                if (Done) begin
                    state_nxt_s = ST_ERROR;
                    err_set_s   = 1'b1;
                    err_val_s   = ERR_SPUR;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                wd_en_s = 1'b1;
                // Done beats a simultaneous timeout; a Stop arriving with Done still counts.
                if (Done) begin
                    icount_inc_s = 1'b1;
                    if (stop_pending_r || Stop) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end else if (wd_expire_s) begin
                    state_nxt_s = ST_ERROR;
                    err_set_s   = 1'b1;
                    err_val_s   = ERR_WDOG;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_HALTED, ST_ERROR: begin
                if (Start) begin
                    clr_s       = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath registers and status outputs (decoded from next state).
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r        <= ST_IDLE;
            pc_r           <= {AW{1'b0}};
            icount_r       <= 16'h0000;
            din_r          <= 16'h0000;
            errcode_r      <= ERR_NONE;
            stop_pending_r <= 1'b0;
            run_r          <= 1'b0;
            memrd_r        <= 1'b0;
            busy_r         <= 1'b0;
            halted_r       <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            state_r <= state_nxt_s;

            if (clr_s) begin
                pc_r <= {AW{1'b0}};
            end else if (pc_inc_s) begin
                pc_r <= pc_r + AW'(1'b1);
            end

            if (clr_s) begin
                icount_r <= 16'h0000;
            end else if (icount_inc_s) begin
                icount_r <= icount_r + 16'h0001;
            end

            if (state_r == ST_DECODE) begin
                din_r <= MemData;
            end

            if (clr_s) begin
                errcode_r <= ERR_NONE;
            end else if (err_set_s) begin
                errcode_r <= err_val_s;
            end

            if (clr_s || (state_nxt_s == ST_IDLE)) begin
                stop_pending_r <= 1'b0;
            end else if (Stop && (is_busy_state(state_r) || ((state_r == ST_IDLE) && Start))) begin
                stop_pending_r <= 1'b1;
            end

            run_r    <= (state_nxt_s == ST_ISSUE);
            memrd_r  <= (state_nxt_s == ST_FETCH);
            busy_r   <= is_busy_state(state_nxt_s);
            halted_r <= (state_nxt_s == ST_HALTED);
            error_r  <= (state_nxt_s == ST_ERROR);
        end
    end

    assign MemAddr    = pc_r;
    assign PC         = pc_r;
    assign MemRd      = memrd_r;
    assign DIN        = din_r;
    assign Run        = run_r;
    assign InstrCount = icount_r;
    assign Busy       = busy_r;
    assign Halted     = halted_r;
    assign Error      = error_r;
    assign ErrCode    = errcode_r;

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// Directed bench for proc_seq_ctrl with a small behavioural core model (r0..r7,
// mv/mvt/add/sub) and a second AW=2 instance for PC wrap.
module tb_proc_seq_ctrl;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Stop  = 1'b0;
    logic [7:0]  MemAddr;
    logic        MemRd;
    logic [15:0] MemData;
    logic [15:0] DIN;
    logic        Run;
    logic        Done;
    logic [7:0]  PC;
    logic [15:0] InstrCount;
    logic        Busy, Halted, Error;
    logic [1:0]  ErrCode;

    logic        start2 = 1'b0;
    logic        stop2  = 1'b0;
    logic [1:0]  memaddr2;
    logic        memrd2;
    logic [15:0] din2;
    logic        run2;
    logic        done2;
    logic [1:0]  pc2;
    logic [15:0] icount2;
    logic        busy2, halted2, error2;
    logic [1:0]  errcode2;
    logic        run2_d = 1'b0;

    logic [15:0] mem [256];
    logic        done_en    = 1'b1;
    logic        force_done = 1'b0;
    int          lat        = 1;
    logic [15:0] regs [8];
    logic        core_busy  = 1'b0;
    logic [3:0]  core_cnt   = 4'd0;
    logic [15:0] ir         = 16'h0000;
    logic [15:0] op2;

    int          checks = 0;
    int          errors = 0;
    int          run_count = 0;
    int          run_multi = 0;
    logic        run_prev = 1'b0;
    int          base;
    logic [1:0]  pcs [8];
    int          n2 = 0;

    always #5 Clock = ~Clock;

    proc_seq_ctrl #(.AW(8), .TIMEOUT(8)) u_dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop),
        .MemAddr(MemAddr), .MemRd(MemRd), .MemData(MemData),
        .DIN(DIN), .Run(Run), .Done(Done),
        .PC(PC), .InstrCount(InstrCount),
        .Busy(Busy), .Halted(Halted), .Error(Error), .ErrCode(ErrCode)
    );

    proc_seq_ctrl #(.AW(2), .TIMEOUT(8)) u_dut2 (
        .Clock(Clock), .Reset(Reset), .Start(start2), .Stop(stop2),
        .MemAddr(memaddr2), .MemRd(memrd2), .MemData(16'h0000),
        .DIN(din2), .Run(run2), .Done(done2),
        .PC(pc2), .InstrCount(icount2),
        .Busy(busy2), .Halted(halted2), .Error(error2), .ErrCode(errcode2)
    );

    // Synchronous-read program ROM
    always @(posedge Clock) begin
        if (MemRd) MemData <= mem[MemAddr];
    end

    // Core model: latches DIN on Run, raises Done after lat cycles, then executes.
    assign op2  = ir[12] ? {7'b0000000, ir[8:0]} : regs[ir[8:6]];
    assign Done = force_done | (done_en & core_busy & (core_cnt == 4'd0));

    always @(posedge Clock) begin
        if (Reset) begin
            core_busy <= 1'b0;
            core_cnt  <= 4'd0;
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
        end else if (core_busy) begin
            if (core_cnt != 4'd0) begin
                core_cnt <= core_cnt - 4'd1;
            end else if (done_en) begin
                core_busy <= 1'b0;
                case (ir[15:13])
                    3'b000:  regs[ir[11:9]] <= op2;
                    3'b001:  regs[ir[11:9]] <= {ir[7:0], 8'h00};
                    3'b010:  regs[ir[11:9]] <= regs[ir[11:9]] + op2;
                    3'b011:  regs[ir[11:9]] <= regs[ir[11:9]] - op2;
                    default: ;
                endcase
            end
        end else if (Run) begin
            ir        <= DIN;
            core_busy <= 1'b1;
            core_cnt  <= 4'(lat - 1);
        end
    end

    // Run pulse bookkeeping for the main instance
    always @(posedge Clock) begin
        if (Run) run_count = run_count + 1;
        if (Run && run_prev) run_multi = run_multi + 1;
        run_prev = Run;
    end

    // Second instance: Done one cycle after Run, and PC logged at each issue
    always @(posedge Clock) begin
        run2_d <= Reset ? 1'b0 : run2;
        if (run2) begin
            if (n2 < 8) pcs[n2] = pc2;
            n2 = n2 + 1;
        end
    end
    assign done2 = run2_d;

    task automatic step;
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic pulse_start;
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        // Reset state
        do_reset();
        chk("rst_busy", Busy, 0);
        chk("rst_halted", Halted, 0);
        chk("rst_error", Error, 0);
        chk("rst_errcode", ErrCode, 0);
        chk("rst_pc", PC, 0);
        chk("rst_icount", InstrCount, 0);
        chk("rst_din", DIN, 0);
        chk("rst_run", Run, 0);
        chk("rst_memrd", MemRd, 0);

        // mv r0,#5; add r0,#3; HALT
        mem[0] = 16'h1005; mem[1] = 16'h5003; mem[2] = 16'hE000;
        base = run_count;
        pulse_start();
        chk("fetch_memrd", MemRd, 1);
        chk("fetch_busy", Busy, 1);
        chk("fetch_addr", MemAddr, 0);
        for (int i = 0; i < 100; i++) begin
            if (Halted) break;
            step();
        end
        chk("prog_halted", Halted, 1);
        chk("prog_busy", Busy, 0);
        chk("prog_pc", PC, 8'h02);
        chk("prog_icount", InstrCount, 2);
        chk("prog_runs", run_count - base, 2);
        chk("prog_r0", regs[0], 16'h0008);
        chk("prog_din", DIN, 16'hE000);
        chk("prog_run_width", run_multi, 0);

        // Restart from HALTED clears status and counters
        base = run_count;
        pulse_start();
        chk("restart_halted", Halted, 0);
        chk("restart_pc", PC, 0);
        chk("restart_icount", InstrCount, 0);
        chk("restart_busy", Busy, 1);
        for (int i = 0; i < 100; i++) begin
            if (Halted) break;
            step();
        end
        chk("rerun_icount", InstrCount, 2);
        chk("rerun_runs", run_count - base, 2);

        // Illegal opcode
        do_reset();
        mem[0] = 16'h8000;
        base = run_count;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            if (Error) break;
            step();
        end
        chk("ill_error", Error, 1);
        chk("ill_code", ErrCode, 2'b01);
        chk("ill_pc", PC, 0);
        chk("ill_runs", run_count - base, 0);
        chk("ill_busy", Busy, 0);

        // Watchdog: Done held low
        do_reset();
        done_en = 1'b0;
        mem[0] = 16'h0000;
        base = run_count;
        pulse_start();
        step();
        step();
        chk("wd_issue_run", Run, 1);
        step();
        for (int i = 0; i < 7; i++) step();
        chk("wd_not_yet", Error, 0);
        chk("wd_still_busy", Busy, 1);
        step();
        chk("wd_error", Error, 1);
        chk("wd_code", ErrCode, 2'b10);
        chk("wd_runs", run_count - base, 1);
        done_en = 1'b1;

        // Stop during EXEC of the 3rd of 5 subs
        do_reset();
        lat = 3;
        for (int i = 0; i < 5; i++) mem[i] = 16'h7001;
        mem[5] = 16'hE000;
        base = run_count;
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            if (run_count - base >= 3) break;
            step();
        end
        Stop = 1'b1;
        step();
        Stop = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!Busy) break;
            step();
        end
        chk("stop_busy", Busy, 0);
        chk("stop_halted", Halted, 0);
        chk("stop_icount", InstrCount, 3);
        chk("stop_pc", PC, 3);
        chk("stop_runs", run_count - base, 3);
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            if (Halted) break;
            step();
        end
        chk("resume_icount", InstrCount, 5);
        chk("resume_pc", PC, 5);
        chk("resume_r0", regs[0], 16'hFFFB);

        // Single-step with Start=Stop=1
        do_reset();
        lat = 1;
        mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'h1003; mem[3] = 16'h1004;
        mem[4] = 16'hE000;
        base = run_count;
        for (int k = 0; k < 4; k++) begin
            Start = 1'b1;
            Stop  = 1'b1;
            step();
            Start = 1'b0;
            Stop  = 1'b0;
            for (int i = 0; i < 30; i++) begin
                if (!Busy) break;
                step();
            end
            chk("ss_icount", InstrCount, k + 1);
            chk("ss_pc", PC, k + 1);
            chk("ss_r0", regs[0], k + 1);
        end
        chk("ss_runs", run_count - base, 4);

        // Reset mid-EXEC
        mem[4] = 16'h1005;
        lat = 3;
        base = run_count;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            if (run_count - base >= 1) break;
            step();
        end
        chk("mid_busy_before", Busy, 1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("mid_busy", Busy, 0);
        chk("mid_pc", PC, 0);
        chk("mid_icount", InstrCount, 0);
        chk("mid_run", Run, 0);
        lat = 1;

        // Spurious Done in DECODE
        do_reset();
        mem[0] = 16'h1005;
        base = run_count;
        pulse_start();
        step();
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        chk("spur_error", Error, 1);
        chk("spur_code", ErrCode, 2'b11);
        chk("spur_runs", run_count - base, 0);

        // PC wrap on the AW=2 instance
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (n2 >= 5) break;
            step();
        end
        chk("wrap_issues", (n2 >= 5) ? 1 : 0, 1);
        for (int i = 0; i < 5; i++) chk("wrap_pc", pcs[i], i % 4);
        chk("wrap_icount", icount2, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
